comparador_serie_param: RTL

//  Parametrised, multi-cycle magnitude comparator: successor of the fixed 8-bit cascade comparator.

---
 rtl/comparador_serie_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/comparador_serie_param.sv
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands DIGIT bits per clock,
// most-significant digit first, in unsigned or two's-complement mode, with an optional early
// exit on the first differing digit and cascade inputs from a more-significant stage.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/cascade valid          in_ready   block can accept a new pair
//   a, b       operands                        signo      1 = two's-complement compare
//   igual_i    cascade: equal so far           mayor_i    cascade: A already greater
//   menor_i    cascade: A already smaller
//   out_valid  result valid                    out_ready  consumer takes the result
//   igual_o    A == B                          mayor_o    A > B
//   menor_o    A < B                           ciclos_o   compare cycles used for this result
module comparador_serie_param #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIGIT      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               signo,
  input  logic                               igual_i,
  input  logic                               mayor_i,
  input  logic                               menor_i,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               igual_o,
  output logic                               mayor_o,
  output logic                               menor_o,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]   ciclos_o
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CycW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CycW-1:0]   ciclos_q, ciclos_d;
  logic              igual_q, igual_d, mayor_q, mayor_d, menor_q, menor_d;
  logic [DIGIT-1:0]  a_dig, b_dig;

  // igual_i is informational only: with neither mayor_i nor menor_i set, the digits decide.
  logic unused_igual;
  assign unused_igual = igual_i;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    ciclos_d = ciclos_q;
    igual_d  = igual_q;
    mayor_d  = mayor_q;
    menor_d  = menor_q;
    a_dig    = '0;
    b_dig    = '0;

    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d      = a ^ (WIDTH'(signo) << (WIDTH - 1));
          b_d      = b ^ (WIDTH'(signo) << (WIDTH - 1));
          idx_d    = IdxW'(N - 1);
          ciclos_d = '0;
          if (mayor_i) begin
            {igual_d, mayor_d, menor_d} = 3'b010;
            state_d = StDone;
          end else if (menor_i) begin
            {igual_d, mayor_d, menor_d} = 3'b001;
            state_d = StDone;
          end else begin
            {igual_d, mayor_d, menor_d} = 3'b100;
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        ciclos_d = ciclos_q + CycW'(1);
        // Only the first (most significant) differing digit decides.
        if (!(mayor_q || menor_q)) begin
          if (a_dig > b_dig) begin
            {igual_d, mayor_d, menor_d} = 3'b010;
          end else if (a_dig < b_dig) begin
            {igual_d, mayor_d, menor_d} = 3'b001;
          end
        end
        if ((EARLY_EXIT && (mayor_d || menor_d)) || idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      ciclos_q <= '0;
      igual_q  <= 1'b1;
      mayor_q  <= 1'b0;
      menor_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      ciclos_q <= ciclos_d;
      igual_q  <= igual_d;
      mayor_q  <= mayor_d;
      menor_q  <= menor_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign igual_o   = igual_q;
  assign mayor_o   = mayor_q;
  assign menor_o   = menor_q;
  assign ciclos_o  = ciclos_q;

endmodule
